// File: rtl/exec_stage_core.sv
// exec_stage_core: registered WISC execute stage (ALU, branch eval, PC adder, muxing).
// Ports: clk, rst_n (sync, active-low); inA/inB/Cin/invA/invB/aluOp ALU controls;
//   brchSig condition code; incPC/imm8/imm11/immSrc/aluPC PC adder inputs;
//   jalSel/aluJmp/SLBIsel/sOpSel select lines; outputs aluOut/aluFinal/newPC/addPC
//   all registered one cycle after inputs are sampled.
module exec_stage_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] inA,
  input  logic [15:0] inB,
  input  logic        Cin,
  input  logic        invA,
  input  logic        invB,
  input  logic [3:0]  aluOp,
  input  logic [2:0]  brchSig,
  input  logic [15:0] incPC,
  input  logic [15:0] imm8,
  input  logic [15:0] imm11,
  input  logic        immSrc,
  input  logic        aluPC,
  input  logic        jalSel,
  input  logic        aluJmp,
  input  logic        SLBIsel,
  input  logic        sOpSel,
  output logic [15:0] aluOut,
  output logic [15:0] aluFinal,
  output logic [15:0] newPC,
  output logic [15:0] addPC
);

  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [3:0]  w_sh;
  logic [16:0] w_sum;
  logic        w_cf;
  logic        w_sf;
  logic        w_of;
  logic        w_zf;
  logic        w_lt;
  logic [31:0] w_dbl;
  logic [31:0] w_rolw;
  logic [31:0] w_rorw;
  logic [15:0] w_rev;
  logic [15:0] w_res;
  logic        w_jmp;
  logic [15:0] w_base;
  logic [15:0] w_imm;
  logic [15:0] w_comp;
  logic [15:0] w_jpc;
  logic [15:0] w_fin;
  logic [15:0] w_npc;
  logic [15:0] w_apc;

  logic [15:0] r_aluOut;
  logic [15:0] r_aluFinal;
  logic [15:0] r_newPC;
  logic [15:0] r_addPC;

  assign w_a   = invA ? ~inA : inA;
  assign w_b   = invB ? ~inB : inB;
  assign w_sh  = w_b[3:0];
  assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {16'b0, Cin};
  assign w_cf  = w_sum[16];
  assign w_sf  = w_sum[15];
  assign w_of  = (w_a[15] == w_b[15]) && (w_sum[15] != w_a[15]);
  assign w_lt  = w_sf ^ w_of;

  // Rotates come from the upper/lower half of a doubled operand.
  assign w_dbl  = {w_a, w_a};
  assign w_rolw = w_dbl << w_sh;
  assign w_rorw = w_dbl >> w_sh;

  always_comb begin
    w_rev = '0;
    for (int i = 0; i < 16; i++) begin
      w_rev[15-i] = w_a[i];
    end
  end

  always_comb begin
    w_res = '0;
    case (aluOp)
      4'b0000: w_res = w_rolw[31:16];
      4'b0001: w_res = w_a << w_sh;
      4'b0010: w_res = w_rorw[15:0];
      4'b0011: w_res = w_a >> w_sh;
      4'b0100: w_res = w_sum[15:0];
      4'b0101: w_res = w_a & w_b;
      4'b0110: w_res = w_a | w_b;
      4'b0111: w_res = w_a ^ w_b;
      4'b1000: w_res = w_rev;
      4'b1001: w_res = w_b;
      4'b1010: w_res = {w_a[7:0], w_b[7:0]};
      4'b1011: w_res = w_a;
      default: w_res = '0;
    endcase
  end

  assign w_zf = (w_res == 16'h0000);

  always_comb begin
    w_jmp = 1'b0;
    case (brchSig)
      3'b000: w_jmp = 1'b0;
      3'b001: w_jmp = w_zf;
      3'b010: w_jmp = ~w_zf;
      3'b011: w_jmp = w_lt;
      3'b100: w_jmp = ~w_lt;
      3'b101: w_jmp = w_zf | w_lt;
      3'b110: w_jmp = w_cf;
      default: w_jmp = 1'b1;
    endcase
  end

  assign w_base = aluPC ? w_res : incPC;
  assign w_imm  = immSrc ? imm11 : imm8;
  assign w_comp = w_base + w_imm;
  assign w_jpc  = w_jmp ? w_comp : incPC;
  assign w_apc  = jalSel ? incPC : w_jpc;
  assign w_fin  = sOpSel ? {15'b0, w_jmp} : w_res;
  assign w_npc  = SLBIsel ? incPC :
                  (aluJmp ? w_res : w_jpc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_aluOut   <= '0;
      r_aluFinal <= '0;
      r_newPC    <= '0;
      r_addPC    <= '0;
    end else begin
      r_aluOut   <= w_res;
      r_aluFinal <= w_fin;
      r_newPC    <= w_npc;
      r_addPC    <= w_apc;
    end
  end

  assign aluOut   = r_aluOut;
  assign aluFinal = r_aluFinal;
  assign newPC    = r_newPC;
  assign addPC    = r_addPC;

endmodule

// File: tb/tb_exec_stage_core.sv
// tb_exec_stage_core: directed + random stimulus for exec_stage_core
// against a behavioural model built from the datapath rules.
module tb_exec_stage_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] inA, inB, incPC, imm8, imm11;
  logic        Cin, invA, invB;
  logic [3:0]  aluOp;
  logic [2:0]  brchSig;
  logic        immSrc, aluPC, jalSel, aluJmp, SLBIsel, sOpSel;
  logic [15:0] aluOut, aluFinal, newPC, addPC;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] e_out, e_fin, e_npc, e_apc;

  always #5 clk = ~clk;

  exec_stage_core dut (
    .clk(clk), .rst_n(rst_n),
    .inA(inA), .inB(inB), .Cin(Cin),
    .invA(invA), .invB(invB),
    .aluOp(aluOp), .brchSig(brchSig),
    .incPC(incPC), .imm8(imm8), .imm11(imm11),
    .immSrc(immSrc), .aluPC(aluPC),
    .jalSel(jalSel), .aluJmp(aluJmp),
    .SLBIsel(SLBIsel), .sOpSel(sOpSel),
    .aluOut(aluOut), .aluFinal(aluFinal),
    .newPC(newPC), .addPC(addPC)
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model: integer arithmetic and per-bit index maps.
  task automatic model();
    int unsigned a, b, s, sh, r, base, cp, jp;
    int sa, sb, ss;
    bit cf, sf, of, zf, lt, j;
    a  = invA ? (~inA & 16'hFFFF) : inA;
    b  = invB ? (~inB & 16'hFFFF) : inB;
    s  = a + b + Cin;
    cf = (s > 32'hFFFF);
    sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
    sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
    ss = sa + sb + int'(Cin);
    of = (ss > 32767) || (ss < -32768);
    sf = ((s % 65536) >= 32768);
    sh = b % 16;
    r  = 0;
    case (aluOp)
      4'd0: for (int i = 0; i < 16; i++)
              if ((a >> i) & 1) r += (1 << ((i + sh) % 16));
      4'd1: r = (a * (1 << sh)) % 65536;
      4'd2: for (int i = 0; i < 16; i++)
              if ((a >> ((i + sh) % 16)) & 1) r += (1 << i);
      4'd3: r = a / (1 << sh);
      4'd4: r = s % 65536;
      4'd5: r = a & b;
      4'd6: r = a | b;
      4'd7: r = a ^ b;
      4'd8: for (int i = 0; i < 16; i++)
              if ((a >> i) & 1) r += (1 << (15 - i));
      4'd9: r = b;
      4'd10: r = (a % 256) * 256 + (b % 256);
      4'd11: r = a;
      default: r = 0;
    endcase
    zf = (r == 0);
    lt = (sf != of);
    case (brchSig)
      3'd0: j = 0;
      3'd1: j = zf;
      3'd2: j = !zf;
      3'd3: j = lt;
      3'd4: j = !lt;
      3'd5: j = zf || lt;
      3'd6: j = cf;
      default: j = 1;
    endcase
    base  = aluPC ? r : incPC;
    cp    = (base + (immSrc ? imm11 : imm8)) % 65536;
    jp    = j ? cp : incPC;
    e_out = r[15:0];
    e_fin = sOpSel ? {15'b0, j} : r[15:0];
    e_apc = jalSel ? incPC : jp[15:0];
    e_npc = SLBIsel ? incPC : (aluJmp ? r[15:0] : jp[15:0]);
  endtask

  task automatic clr();
    inA = 0; inB = 0; Cin = 0; invA = 0; invB = 0;
    aluOp = 0; brchSig = 0; incPC = 0; imm8 = 0;
    imm11 = 0; immSrc = 0; aluPC = 0; jalSel = 0;
    aluJmp = 0; SLBIsel = 0; sOpSel = 0;
  endtask

  task automatic step(input string tag);
    if (rst_n) model();
    else begin
      e_out = 0; e_fin = 0; e_npc = 0; e_apc = 0;
    end
    @(posedge clk);
    #1;
    chk({tag, ".out"}, aluOut, e_out);
    chk({tag, ".fin"}, aluFinal, e_fin);
    chk({tag, ".npc"}, newPC, e_npc);
    chk({tag, ".apc"}, addPC, e_apc);
  endtask

  initial begin
    clr();
    rst_n = 0;
    inA = 16'h1234; inB = 16'h00F1; aluOp = 4'd4;
    incPC = 16'h0202; imm8 = 16'h0010; brchSig = 3'd7;
    step("rst0");
    step("rst1");
    rst_n = 1;
    step("rel");

    clr();
    inA = 16'h7FFF; inB = 16'h0001; aluOp = 4'd4;
    brchSig = 3'd3; sOpSel = 1;
    step("ovf");
    chk("ovf.k.out", aluOut, 16'h8000);
    chk("ovf.k.fin", aluFinal, 16'h0000);

    clr();
    inA = 16'h0003; inB = 16'h0005; invB = 1; Cin = 1;
    aluOp = 4'd4; brchSig = 3'd3; sOpSel = 1;
    step("sub");
    chk("sub.k.out", aluOut, 16'hFFFE);
    chk("sub.k.fin", aluFinal, 16'h0001);
    brchSig = 3'd6;
    step("subc");
    chk("subc.k.fin", aluFinal, 16'h0000);

    clr();
    incPC = 16'h0010; imm8 = 16'hFFFC; aluOp = 4'd4;
    brchSig = 3'd1;
    step("beq");
    chk("beq.k.npc", newPC, 16'h000C);
    chk("beq.k.apc", addPC, 16'h000C);
    inA = 16'h0001;
    step("bne");
    chk("bne.k.npc", newPC, 16'h0010);

    clr();
    brchSig = 3'd7; immSrc = 1; imm11 = 16'h0100;
    incPC = 16'h0200; jalSel = 1; aluOp = 4'd4;
    step("jal");
    chk("jal.k.npc", newPC, 16'h0300);
    chk("jal.k.apc", addPC, 16'h0200);
    aluJmp = 1; inA = 16'h1234; inB = 16'h0002;
    step("jr");
    chk("jr.k.npc", newPC, 16'h1236);
    SLBIsel = 1;
    step("slbi");
    chk("slbi.k.npc", newPC, 16'h0200);

    clr();
    inA = 16'h8001; inB = 16'h0001;
    aluOp = 4'd0; step("rol"); chk("rol.k", aluOut, 16'h0003);
    aluOp = 4'd1; step("shl"); chk("shl.k", aluOut, 16'h0002);
    aluOp = 4'd2; step("ror"); chk("ror.k", aluOut, 16'hC000);
    aluOp = 4'd3; step("shr"); chk("shr.k", aluOut, 16'h4000);
    inA = 16'h0001; aluOp = 4'd8;
    step("rev"); chk("rev.k", aluOut, 16'h8000);
    inA = 16'h0012; inB = 16'h0034; aluOp = 4'd10;
    step("slb"); chk("slb.k", aluOut, 16'h1234);

    for (int k = 0; k < 400; k++) begin
      rst_n   = ($urandom_range(0, 24) != 0);
      inA     = 16'($urandom);
      inB     = (k % 3 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      Cin     = 1'($urandom);
      invA    = 1'($urandom);
      invB    = 1'($urandom);
      aluOp   = 4'($urandom);
      brchSig = 3'($urandom);
      incPC   = 16'($urandom);
      imm8    = 16'($urandom);
      imm11   = 16'($urandom);
      immSrc  = 1'($urandom);
      aluPC   = 1'($urandom);
      jalSel  = 1'($urandom);
      aluJmp  = 1'($urandom);
      SLBIsel = 1'($urandom);
      sOpSel  = 1'($urandom);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/exec_stage_core.md
# exec_stage_core

Registered execute-stage datapath for the 16-bit WISC pipeline. It combines:
- a 16-bit ALU with operand inversion and carry-in;
- a branch-condition evaluator driven by the ALU flags;
- an unsigned 16-bit PC/immediate adder;
- the PC-select and write-back-select muxing.

It sits between decode and memory. All outputs are registered, one cycle after the inputs are sampled.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- inA, inB  in  16  ALU operands.
- Cin  in  1  adder carry-in.
- invA, invB  in  1  bitwise-invert the corresponding operand before any operation.
- aluOp  in  4  ALU operation select.
- brchSig  in  3  branch/set condition code.
- incPC  in  16  PC+2.
- imm8, imm11  in  16  sign-extended immediates.
- immSrc  in  1  0 selects imm8, 1 selects imm11.
- aluPC  in  1  PC-adder base: 1 = ALU result, 0 = incPC.
- jalSel  in  1  addPC returns incPC (link value).
- aluJmp  in  1  newPC takes the ALU result (JR/JALR).
- SLBIsel  in  1  force newPC = incPC.
- sOpSel  in  1  aluFinal = zero-extended condition bit.
- aluOut  out  16  registered raw ALU result.
- aluFinal  out  16  registered write-back value.
- newPC  out  16  registered next PC.
- addPC  out  16  registered link/jump value.

## Operation
- Operands: A' = invA ? ~inA : inA; B' = invB ? ~inB : inB.
- Adder: {cout, sum} = A' + B' + Cin, computed for every aluOp.
  - cf = carry out.
  - sf = sum[15].
  - of = signed overflow, i.e. A'[15]==B'[15] && sum[15]!=A'[15].
- Shift amount sh = B'[3:0].
- aluOp encoding:
  - 0000 rotate left A' by sh.
  - 0001 shift left logical.
  - 0010 rotate right.
  - 0011 shift right logical.
  - 0100 ADD (sum).
  - 0101 A'&B'.
  - 0110 A'|B'.
  - 0111 A'^B'.
  - 1000 bit-reverse A' (bit i goes to bit 15-i).
  - 1001 pass B'.
  - 1010 SLBI result, {A'[7:0], B'[7:0]}.
  - 1011 pass A'.
  - 1100–1111 produce 0x0000.
- zf = (ALU result == 0).
- jmpSel by brchSig:
  - 000 → 0.
  - 001 → zf.
  - 010 → !zf.
  - 011 → sf^of.
  - 100 → !(sf^of).
  - 101 → zf|(sf^of).
  - 110 → cf.
  - 111 → 1.
- Write-back: aluFinal = sOpSel ? {15'b0, jmpSel} : ALU result.
- PC adder:
  - base = aluPC ? ALU result : incPC.
  - imm = immSrc ? imm11 : imm8.
  - compPC = base + imm, modulo 2^16, carry discarded.
- PC and link selection:
  - jmpPC = jmpSel ? compPC : incPC.
  - addPC = jalSel ? incPC : jmpPC.
  - newPC = SLBIsel ? incPC : (aluJmp ? ALU result : jmpPC). SLBIsel has highest priority, then aluJmp.
- All arithmetic wraps modulo 2^16; no exceptions raised.

## Timing
- Combinational evaluation of all sampled inputs; results registered on the rising clk edge. Latency is exactly 1 cycle, throughput 1 per cycle, with no handshake or stall.
- rst_n low at a rising edge: aluOut, aluFinal, newPC and addPC all become 0x0000, regardless of the other inputs. Reset takes precedence in the same cycle.
- First post-reset edge with rst_n high loads normally.
- No internal state besides the output registers. Back-to-back operations are independent.

## Test plan
- **Reset:** drive nonzero inputs with rst_n=0 for 2 edges → all four outputs are 0x0000. Release rst_n → the next edge loads the computed values.
- **Overflow:** inA=0x7FFF, inB=0x0001, aluOp=0100, Cin=0, brchSig=011, sOpSel=1 → aluOut=0x8000, aluFinal=0x0000 (sf=1, of=1).
- **Subtract/compare:** inA=0x0003, inB=0x0005, invB=1, Cin=1, aluOp=0100, brchSig=011, sOpSel=1 → aluOut=0xFFFE, aluFinal=0x0001. Same with brchSig=110 → aluFinal=0x0000.
- **Conditional branch:** incPC=0x0010, imm8=0xFFFC, immSrc=0, aluOp=0100, brchSig=001.
  - inA=inB=0 → newPC=0x000C, addPC=0x000C.
  - inA=0x0001 → newPC=0x0010.
- **Jumps:**
  - brchSig=111, immSrc=1, imm11=0x0100, incPC=0x0200, jalSel=1 → newPC=0x0300, addPC=0x0200.
  - aluJmp=1, inA=0x1234, inB=0x0002, aluOp=0100 → newPC=0x1236.
  - Adding SLBIsel=1 → newPC=0x0200.
- **Shifts/misc:** inA=0x8001, inB=0x0001.
  - aluOp 0000 → 0x0003; 0001 → 0x0002; 0010 → 0xC000; 0011 → 0x4000.
  - aluOp 1000 with inA=0x0001 → 0x8000.
  - aluOp 1010 with inA=0x0012, inB=0x0034 → 0x1234.
